// File: rtl/enigma_encode_path.sv
// enigma_encode_path: keystroke sequencer plus rotor/reflector substitution datapath.
// Define PLUGBOARD_EN to add the writable plugboard table and its entry/exit stages.
module enigma_encode_path #(
  parameter int SETTLE = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [4:0] in_char,
  output logic       rotate,
  input  logic [4:0] rotor1,
  input  logic [4:0] rotor2,
  input  logic [4:0] rotor3,
  input  logic [2:0] rotor_type_1,
  input  logic [2:0] rotor_type_2,
  input  logic [2:0] rotor_type_3,
  input  logic       plug_we,
  input  logic [4:0] plug_addr,
  input  logic [4:0] plug_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [4:0] out_char,
  output logic       out_err
);

`ifdef PLUGBOARD_EN
  localparam int NST = 9;
`else
  localparam int NST = 7;
`endif

  localparam logic [207:0] WIRE_I   = "EKMFLGDQVZNTOWYHXUSPAIBRCJ";
  localparam logic [207:0] WIRE_II  = "AJDKSIRUXBLHWTMCQGZNPYFVOE";
  localparam logic [207:0] WIRE_III = "BDFHJLCPRTXVZNYEIWGAKMUSQO";
  localparam logic [207:0] WIRE_IV  = "ESOVPZJAYQUIRHXLNFTGKDCMWB";
  localparam logic [207:0] WIRE_V   = "VZBRGITYUPSDNHLXAWMJQOFECK";
  localparam logic [207:0] UKW_B    = "YRUHQSLDPXNGOKMIEBFZCWVJAT";

  typedef enum logic [2:0] {IDLE, STEP, WAIT, ENC, OUT} state_t;

  state_t     state, state_next;
  logic [3:0] cnt;
  logic [4:0] cur_char;
  logic       err;
  logic [4:0] p1_q, p2_q, p3_q;
  logic [2:0] t1_q, t2_q, t3_q;
  logic [4:0] p1, p2, p3;
  logic [2:0] t1, t2, t3;
  logic       first_enc;
  logic [3:0] core_idx;
  logic [4:0] stage_out;

  // Wiring tables are stored as ASCII strings, leftmost character is index 0.
  function automatic logic [4:0] table_at(input logic [207:0] tbl, input logic [4:0] idx);
    logic [7:0] sh;
    logic [7:0] ch;
    sh = {3'b000, 5'd25 - idx} << 3;
    ch = tbl[sh +: 8];
    return 5'(ch - 8'd65);
  endfunction

  function automatic logic [4:0] wire_fwd(input logic [2:0] t, input logic [4:0] idx);
    logic [4:0] r;
    case (t)
      3'd0:    r = table_at(WIRE_I, idx);
      3'd1:    r = table_at(WIRE_II, idx);
      3'd2:    r = table_at(WIRE_III, idx);
      3'd3:    r = table_at(WIRE_IV, idx);
      3'd4:    r = table_at(WIRE_V, idx);
      default: r = idx;
    endcase
    return r;
  endfunction

  function automatic logic [4:0] wire_inv(input logic [2:0] t, input logic [4:0] c);
    logic [4:0] r;
    r = c;
    for (int i = 0; i < 26; i++)
      if (wire_fwd(t, 5'(i)) == c) r = 5'(i);
    return r;
  endfunction

  function automatic logic [4:0] add26(input logic [4:0] a, input logic [4:0] b);
    logic [5:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 6'd26) s = s - 6'd26;
    return s[4:0];
  endfunction

  function automatic logic [4:0] sub26(input logic [4:0] a, input logic [4:0] b);
    logic [5:0] s;
    s = {1'b0, a} - {1'b0, b};
    if (a < b) s = s + 6'd26;
    return s[4:0];
  endfunction

  function automatic logic [4:0] norm26(input logic [4:0] p);
    return (p >= 5'd26) ? p - 5'd26 : p;
  endfunction

  function automatic logic [4:0] rotor_stage(input logic inv, input logic [2:0] t,
                                             input logic [4:0] p, input logic [4:0] c);
    logic [4:0] idx;
    logic [4:0] w;
    idx = add26(c, p);
    w   = inv ? wire_inv(t, idx) : wire_fwd(t, idx);
    return sub26(w, p);
  endfunction

`ifdef PLUGBOARD_EN
  logic [4:0] plug_tbl [26];
  logic [4:0] plug_act [26];

  // The active copy is frozen at accept so mid-letter writes only affect the next letter.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 26; i++) begin
        plug_tbl[i] <= 5'(i);
        plug_act[i] <= 5'(i);
      end
    end else begin
      if (plug_we && (plug_addr < 5'd26)) plug_tbl[plug_addr] <= plug_data;
      if ((state == IDLE) && in_valid) plug_act <= plug_tbl;
    end
  end
`else
  logic unused_plug;
  assign unused_plug = ^{plug_we, plug_addr, plug_data};
`endif

  // Live rotor inputs feed the first ENC cycle; later stages use the copy latched then.
  assign first_enc = (state == ENC) && (cnt == 4'd0);

  always_comb begin
    p1 = first_enc ? norm26(rotor1) : p1_q;
    p2 = first_enc ? norm26(rotor2) : p2_q;
    p3 = first_enc ? norm26(rotor3) : p3_q;
    t1 = first_enc ? rotor_type_1 : t1_q;
    t2 = first_enc ? rotor_type_2 : t2_q;
    t3 = first_enc ? rotor_type_3 : t3_q;
  end

  always_comb begin
    stage_out = cur_char;
    core_idx  = cnt;
`ifdef PLUGBOARD_EN
    core_idx = cnt - 4'd1;
    if ((cnt == 4'd0) || (cnt == 4'(NST - 1))) begin
      core_idx = 4'd15;
      if (!err) stage_out = plug_act[cur_char];
    end
`endif
    if (!err) begin
      case (core_idx)
        4'd0:    stage_out = rotor_stage(1'b0, t3, p3, cur_char);
        4'd1:    stage_out = rotor_stage(1'b0, t2, p2, cur_char);
        4'd2:    stage_out = rotor_stage(1'b0, t1, p1, cur_char);
        4'd3:    stage_out = table_at(UKW_B, cur_char);
        4'd4:    stage_out = rotor_stage(1'b1, t1, p1, cur_char);
        4'd5:    stage_out = rotor_stage(1'b1, t2, p2, cur_char);
        4'd6:    stage_out = rotor_stage(1'b1, t3, p3, cur_char);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    rotate     = 1'b0;
    out_valid  = 1'b0;
    out_char   = cur_char;
    out_err    = err;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = STEP;
      end
      STEP: begin
        rotate     = 1'b1;
        state_next = WAIT;
      end
      WAIT: if (cnt == 4'(SETTLE - 1)) state_next = ENC;
      ENC:  if (cnt == 4'(NST - 1)) state_next = OUT;
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // cnt times the settle wait, then indexes the substitution stage.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt      <= 4'd0;
      cur_char <= 5'd0;
      err      <= 1'b0;
      p1_q     <= 5'd0;
      p2_q     <= 5'd0;
      p3_q     <= 5'd0;
      t1_q     <= 3'd0;
      t2_q     <= 3'd0;
      t3_q     <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= 4'd0;
          if (in_valid) begin
            cur_char <= in_char;
            err      <= (in_char > 5'd25);
          end
        end
        STEP: cnt <= 4'd0;
        WAIT: cnt <= (cnt == 4'(SETTLE - 1)) ? 4'd0 : cnt + 4'd1;
        ENC: begin
          if (first_enc) begin
            p1_q <= p1;
            p2_q <= p2;
            p3_q <= p3;
            t1_q <= t1;
            t2_q <= t2;
            t3_q <= t3;
          end
          cur_char <= stage_out;
          cnt      <= cnt + 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_enigma_encode_path.sv
// Scoreboard bench for enigma_encode_path: directed keys with hand-computed ciphertext.
// A local rotor model advances the fast rotor on each rotate pulse.
module tb_enigma_encode_path;

`ifdef PLUGBOARD_EN
  localparam int LAT = 14;
`else
  localparam int LAT = 12;
`endif

  logic       clock;
  logic       reset_n;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] in_char;
  logic       rotate;
  logic [4:0] rotor1, rotor2, rotor3;
  logic [2:0] rotor_type_1, rotor_type_2, rotor_type_3;
  logic       plug_we;
  logic [4:0] plug_addr, plug_data;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] out_char;
  logic       out_err;

  int checks = 0;
  int failures = 0;
  logic [5:0] exp_q[$];
  logic [5:0] mon_e;
  logic       load_req;
  logic [4:0] load_val;
  int rot_cnt, rot_first, lat;

  enigma_encode_path dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_char(in_char), .rotate(rotate), .rotor1(rotor1), .rotor2(rotor2),
    .rotor3(rotor3), .rotor_type_1(rotor_type_1), .rotor_type_2(rotor_type_2),
    .rotor_type_3(rotor_type_3), .plug_we(plug_we), .plug_addr(plug_addr),
    .plug_data(plug_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_char(out_char), .out_err(out_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Stand-in for the rotor stepping block: only the fast rotor moves in these tests.
  always @(posedge clock) begin
    if (load_req)    rotor3 <= load_val;
    else if (rotate) rotor3 <= (rotor3 == 5'd25) ? 5'd0 : rotor3 + 5'd1;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  always @(negedge clock) begin
    if (reset_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_output", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("out_char", int'(out_char), int'(mon_e[4:0]));
        checkOutput("out_err", int'(out_err), int'(mon_e[5]));
      end
    end
  end

  task automatic setup(input logic [2:0] ta, input logic [2:0] tb, input logic [2:0] tc,
                       input logic [4:0] pa, input logic [4:0] pb, input logic [4:0] pc);
    rotor_type_1 = ta;
    rotor_type_2 = tb;
    rotor_type_3 = tc;
    rotor1 = pa;
    rotor2 = pb;
    load_val = pc;
    load_req = 1'b1;
    @(posedge clock);
    #1 load_req = 1'b0;
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (exp_q.size() != 0) begin
      checkOutput("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  task automatic applyStimulus(input logic [4:0] c, input logic [4:0] exp_c,
                               input logic exp_e, input logic wait_done);
    int n;
    n = 0;
    @(negedge clock);
    while (!in_ready && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (!in_ready) begin
      checkOutput("accept_timeout", 0, 1);
      return;
    end
    in_valid = 1'b1;
    in_char  = c;
    exp_q.push_back({exp_e, exp_c});
    @(posedge clock);
    #1 in_valid = 1'b0;
    rot_cnt = 0;
    rot_first = -1;
    lat = -1;
    for (int k = 0; k < 60 && lat < 0; k++) begin
      @(negedge clock);
      if (rotate) begin
        rot_cnt++;
        if (rot_first < 0) rot_first = k;
      end
      if (out_valid) lat = k;
    end
    if (wait_done) waitDrain();
  endtask

  task automatic plugWrite(input logic [4:0] a, input logic [4:0] d);
    @(negedge clock);
    plug_we = 1'b1;
    plug_addr = a;
    plug_data = d;
    @(posedge clock);
    #1 plug_we = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic ok_char, ok_ready, ok_rot;
    reset_n = 1'b0;
    in_valid = 1'b0;
    in_char = 5'd0;
    out_ready = 1'b1;
    plug_we = 1'b0;
    plug_addr = 5'd0;
    plug_data = 5'd0;
    load_req = 1'b0;
    load_val = 5'd0;
    rotor1 = 5'd0;
    rotor2 = 5'd0;
    rotor_type_1 = 3'd0;
    rotor_type_2 = 3'd0;
    rotor_type_3 = 3'd0;
    repeat (3) @(posedge clock);
    #1;
    checkOutput("reset_in_ready", int'(in_ready), 1);
    checkOutput("reset_rotate", int'(rotate), 0);
    checkOutput("reset_out_valid", int'(out_valid), 0);
    checkOutput("reset_out_char", int'(out_char), 0);
    checkOutput("reset_out_err", int'(out_err), 0);
    reset_n = 1'b1;

    // Rotors I,II,III from AAA: AAAAA -> BDZGO
    setup(3'd0, 3'd1, 3'd2, 5'd0, 5'd0, 5'd0);
    applyStimulus(5'd0, 5'd1, 1'b0, 1'b1);
    checkOutput("rotate_pulses", rot_cnt, 1);
    checkOutput("rotate_cycle", rot_first, 0);
    checkOutput("latency", lat, LAT);
    applyStimulus(5'd0, 5'd3, 1'b0, 1'b1);
    applyStimulus(5'd0, 5'd25, 1'b0, 1'b1);
    applyStimulus(5'd0, 5'd6, 1'b0, 1'b1);
    applyStimulus(5'd0, 5'd14, 1'b0, 1'b1);

    // Reciprocity: BDZGO -> AAAAA
    setup(3'd0, 3'd1, 3'd2, 5'd0, 5'd0, 5'd0);
    applyStimulus(5'd1, 5'd0, 1'b0, 1'b1);
    applyStimulus(5'd3, 5'd0, 1'b0, 1'b1);
    applyStimulus(5'd25, 5'd0, 1'b0, 1'b1);
    applyStimulus(5'd6, 5'd0, 1'b0, 1'b1);
    applyStimulus(5'd14, 5'd0, 1'b0, 1'b1);

    // Identity rotors at position 25: exercises the c+p wrap, output is reflector only
    setup(3'd5, 3'd5, 3'd5, 5'd25, 5'd25, 5'd24);
    applyStimulus(5'd25, 5'd19, 1'b0, 1'b1);
    applyStimulus(5'd0, 5'd24, 1'b0, 1'b1);

    applyStimulus(5'd28, 5'd28, 1'b1, 1'b1);
    checkOutput("err_rotate_pulses", rot_cnt, 1);

    // Backpressure: result held, no accept, no extra steps
    setup(3'd0, 3'd1, 3'd2, 5'd0, 5'd0, 5'd0);
    @(posedge clock);
    #1 out_ready = 1'b0;
    applyStimulus(5'd0, 5'd1, 1'b0, 1'b0);
    in_valid = 1'b1;
    in_char = 5'd3;
    ok_char = 1'b1;
    ok_ready = 1'b1;
    ok_rot = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (!out_valid || out_char != 5'd1 || out_err) ok_char = 1'b0;
      if (in_ready) ok_ready = 1'b0;
      if (rotate) ok_rot = 1'b0;
    end
    in_valid = 1'b0;
    checkOutput("bp_out_stable", int'(ok_char), 1);
    checkOutput("bp_in_ready_low", int'(ok_ready), 1);
    checkOutput("bp_no_rotate", int'(ok_rot), 1);
    checkOutput("bp_rotor3_steps", int'(rotor3), 1);
    @(posedge clock);
    #1 out_ready = 1'b1;
    waitDrain();
    applyStimulus(5'd0, 5'd3, 1'b0, 1'b1);

    // Reset while waiting for rotors to settle drops the letter
    setup(3'd0, 3'd1, 3'd2, 5'd0, 5'd0, 5'd0);
    @(negedge clock);
    in_valid = 1'b1;
    in_char = 5'd2;
    @(posedge clock);
    #1 in_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    checkOutput("midreset_rotate", int'(rotate), 0);
    checkOutput("midreset_out_valid", int'(out_valid), 0);
    checkOutput("midreset_in_ready", int'(in_ready), 1);
    checkOutput("midreset_out_char", int'(out_char), 0);
    @(posedge clock);
    #1 reset_n = 1'b1;
    repeat (30) @(negedge clock);

    // Plugboard A<->Z: AAB gives U with the table, B without it
    plugWrite(5'd0, 5'd25);
    plugWrite(5'd25, 5'd0);
    plugWrite(5'd30, 5'd7);
    setup(3'd0, 3'd1, 3'd2, 5'd0, 5'd0, 5'd0);
`ifdef PLUGBOARD_EN
    applyStimulus(5'd0, 5'd20, 1'b0, 1'b1);
`else
    applyStimulus(5'd0, 5'd1, 1'b0, 1'b1);
`endif
    checkOutput("plug_latency", lat, LAT);

    repeat (5) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
